// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: operand width and the
// state encoding of the floating-point adder arbiter.
package softmax_pkg;

  localparam int unsigned DATALENGTH = 32;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_SEND_A = 3'd1,
    ARB_SEND_B = 3'd2,
    ARB_WAIT_Z = 3'd3,
    ARB_RESP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin picker: the search begins one past the
// pointer (wrapping) and the first set request bit wins.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  // Walk NREQ candidates starting at ptr+1; the pointer itself is checked last.
  always_comb begin
    int unsigned cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[IDXW'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder between NREQ requesters. One request is
// served at a time: operands are latched at the grant, pushed through the
// adder's A/B/Z handshakes, and the sum is returned with a one-cycle Done.
module fp_add_arbiter #(
  parameter int unsigned DATALENGTH = softmax_pkg::DATALENGTH,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDXW       = $clog2(NREQ)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            Req,
  input  logic [NREQ*DATALENGTH-1:0] OpA,
  input  logic [NREQ*DATALENGTH-1:0] OpB,
  output logic [NREQ-1:0]            Gnt,
  output logic [NREQ-1:0]            Done,
  output logic [DATALENGTH-1:0]      Result,
  output logic                       Busy,
  output logic [DATALENGTH-1:0]      AddA,
  output logic [DATALENGTH-1:0]      AddB,
  output logic                       AStb,
  output logic                       BStb,
  input  logic                       AAck,
  input  logic                       BAck,
  input  logic [DATALENGTH-1:0]      ZIn,
  input  logic                       ZStb,
  output logic                       ZAck
);
  import softmax_pkg::*;

  arb_state_e            state_q;
  logic [IDXW-1:0]       ptr_q;
  logic [IDXW-1:0]       gnt_idx_q;
  logic [NREQ-1:0]       gnt_q;
  logic [NREQ-1:0]       done_q;
  logic [DATALENGTH-1:0] result_q;
  logic [DATALENGTH-1:0] add_a_q;
  logic [DATALENGTH-1:0] add_b_q;

  logic [IDXW-1:0]       pick_idx;
  logic                  pick_valid;
  logic [DATALENGTH-1:0] sel_a;
  logic [DATALENGTH-1:0] sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i   (Req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Select the winning requester's operand slices for capture at the grant edge.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        sel_a = OpA[i*DATALENGTH +: DATALENGTH];
        sel_b = OpB[i*DATALENGTH +: DATALENGTH];
      end
    end
  end

  // Arbitration and adder handshake sequencing; Done is a one-cycle pulse in RESP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= IDXW'(NREQ - 1);
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_idx_q <= pick_idx;
            gnt_q     <= NREQ'(1) << pick_idx;
            add_a_q   <= sel_a;
            add_b_q   <= sel_b;
            state_q   <= ARB_SEND_A;
          end
        end
        ARB_SEND_A: begin
          if (AStb && AAck) state_q <= ARB_SEND_B;
        end
        ARB_SEND_B: begin
          if (BStb && BAck) state_q <= ARB_WAIT_Z;
        end
        ARB_WAIT_Z: begin
          if (ZStb && ZAck) begin
            result_q <= ZIn;
            done_q   <= gnt_q;
            state_q  <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          gnt_q   <= '0;
          ptr_q   <= gnt_idx_q;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign Gnt    = gnt_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign AddA   = add_a_q;
  assign AddB   = add_b_q;
  assign Busy   = (state_q != ARB_IDLE);
  assign AStb   = (state_q == ARB_SEND_A);
  assign BStb   = (state_q == ARB_SEND_B);
  assign ZAck   = (state_q == ARB_WAIT_Z);

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter that shares one single-precision floating-point `adder` instance between `NREQ` requesters, such as the softmax accumulation path and neighbouring reduction units. It accepts one addition request at a time, latches that requester's operands, and drives the adder's three stb/ack handshakes (A, B, Z). It returns the sum to the granted requester with a one-cycle `Done` pulse. It sits between the requesters and a single `adder`, and is the only master of that adder.

## Interface
- `DATALENGTH`, 32: operand/result width (IEEE-754 single).
- `NREQ`, 4: number of requesters, ≥2.
- `IDXW`, `$clog2(NREQ)`: index width.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: reset is synchronous and active-high.
- `Req` in NREQ: level request; held until own `Done`.
- `OpA` in NREQ*DATALENGTH: packed, slice i is requester i's operand A.
- `OpB` in NREQ*DATALENGTH: packed, slice i is requester i's operand B.
- `Gnt` out NREQ: one-hot; the requester currently being served.
- `Done` out NREQ: one-cycle pulse to the served requester; `Result` is valid in that cycle.
- `Result` out DATALENGTH: last sum; holds until the next completion.
- `Busy` out 1: high in any state except IDLE.
- `AddA`, `AddB` out DATALENGTH: operands to the adder.
- `AStb`, `BStb` out 1: adder input strobes.
- `AAck`, `BAck` in 1: adder input acks.
- `ZIn` in DATALENGTH: adder output.
- `ZStb` in 1: adder output strobe.
- `ZAck` out 1: adder output ack.

## Operation
- States:
  - IDLE: if any `Req` bit is set, pick the winner, register `Gnt`, latch `OpA`/`OpB` slices into `AddA`/`AddB`, go to SEND_A.
  - SEND_A: `AStb`=1; on an edge with `AStb&AAck`, go to SEND_B.
  - SEND_B: `BStb`=1; on an edge with `BStb&BAck`, go to WAIT_Z.
  - WAIT_Z: `ZAck`=1; on an edge with `ZStb&ZAck`, set `Result`←`ZIn`, pulse `Done[g]`, go to RESP.
  - RESP: `Done[g]`=1 for this cycle only. Clear `Gnt`, set pointer←g, go to IDLE.
- Strobes and acks are pure decodes of the registered state. `AStb` is high only in SEND_A, `BStb` only in SEND_B, `ZAck` only in WAIT_Z.
- Arbitration is round-robin. Search starts at pointer+1 mod NREQ and the first set `Req` bit wins. The reset pointer is NREQ-1, so requester 0 has first priority.
- Operands are captured at the grant edge. A requester may change `OpA`/`OpB` after `Gnt` rises.
- No arbitration happens in RESP. The requester drops `Req` on seeing `Done`, so it is not re-granted.
- `Req[g]` dropped mid-transaction: the transaction completes normally and `Done[g]` still pulses. The requester ignores it.
- `Req` bits not granted have no effect until IDLE.
- Reset in any state:
  - State goes to IDLE and the pointer to NREQ-1.
  - All outputs go to 0: `Gnt`, `Done`, `Result`, `Busy`, `AddA`, `AddB`, `AStb`, `BStb`, `ZAck`.
  - The adder shares `Reset` and restarts with the arbiter.
- The arbiter does no arithmetic. `Result` is `ZIn` bit-exact.

## Timing
- Grant latency: 1 cycle from `Req` seen in IDLE to `Gnt`/`AStb` high.
- Each handshake phase lasts at least 1 cycle and has no timeout. A strobe stays high until its ack is sampled with it.
- Minimum turnaround is IDLE 1 + SEND_A 1 + SEND_B 1 + WAIT_Z (adder latency) + RESP 1.
- After RESP the next grant comes at the earliest 2 cycles later (IDLE then SEND_A).
- `Done` is high for exactly 1 cycle per transaction, only to the granted index.
- `Gnt` is at most one-hot at all times.

## Structure
- Shared package `softmax_pkg`: `DATALENGTH` and the state encodings `ARB_IDLE`, `ARB_SEND_A`, `ARB_SEND_B`, `ARB_WAIT_Z`, `ARB_RESP` (3-bit).
- One sub-module, `rr_pick`. It is combinational: given `Req` and the pointer, it outputs a winner index and a valid flag.
- The state machine and operand/result registers live in `fp_add_arbiter`.
- The bench instantiates the real `adder` behind the arbiter, plus an `adder` stub with programmable ack delays.

## Test plan
- Single request: `Req`=0001, A=0x3F800000, B=0x40000000. Expect `Result`=0x40400000, `Done`=0001 for 1 cycle, and `Gnt` returns to 0.
- Simultaneous `Req`=1111 with distinct operands. Expect grants in order 0,1,2,3, four `Done` pulses, and each `Result` matching its pair.
- Fairness: requesters 0 and 2 re-request immediately after each `Done`. Expect service alternating 0,2,0,2 with no starvation.
- Stub delays `AAck` by 5 cycles and `ZStb` by 7. Expect `AStb` held high all 5 cycles, no early phase advance, and a correct `Result`.
- `Reset` asserted during WAIT_Z. Expect every output 0 on the next cycle and the next `Req`=0100 granted to requester 2 with a correct sum.
- `Req[1]` dropped in SEND_B. Expect the transaction to complete, `Done[1]` to pulse once, and no re-grant to requester 1.
